sram_controller: RTL and testbench

// Multi-cycle MEM-stage access unit between the EXE/MEM pipeline register and a
// 16-bit-wide asynchronous external SRAM.
// - Turns one 32-bit load/store into two 16-bit SRAM half-word accesses.
// - Drops ready while busy; the pipeline freezes all stages on ~ready.
// - Delivers the loaded word to the MEM/WB register.

---
 rtl/sram_controller.sv | 114 +++++++++++
 tb/tb_sram_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// MEM-stage access unit: splits each 32-bit load/store into two 16-bit accesses
// on an asynchronous SRAM and stalls the pipeline through ready while busy.
module sram_controller #(
   parameter int ACCESS_CYCLES = 3,
   parameter int BASE_ADDR     = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] sram_dq,
   output logic [17:0] sram_addr,
   output logic        sram_we_n,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

   localparam logic [1:0] CNT_LAST = 2'(ACCESS_CYCLES - 1);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        op_wr_q, op_wr_d;
   logic [16:0] word_q, word_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] offset;
   logic        drive_dq;
   logic        unused_offset_bits;

   // Byte offset from the SRAM base; word index is bits [18:2], higher bits wrap away.
   assign offset             = address - 32'(BASE_ADDR);
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

   assign sram_ce_n   = 1'b0;
   assign sram_oe_n   = 1'b0;
   assign sram_ub_n   = 1'b0;
   assign sram_lb_n   = 1'b0;
   assign read_data   = rdata_q;
   assign dbg_state_o = state_q;
   assign sram_dq     = drive_dq ? ((state_q == HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_wr_d   = op_wr_q;
      word_d    = word_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ready     = 1'b0;
      sram_addr = '0;
      sram_we_n = 1'b1;
      drive_dq  = 1'b0;
      case (state_q)
         IDLE: begin
            // Combinational so the pipeline freezes in the very cycle of the request.
            ready = ~(rd_en | wr_en);
            if (rd_en | wr_en) begin
               op_wr_d = wr_en;
               word_d  = offset[18:2];
               wdata_d = write_data;
               cnt_d   = '0;
               state_d = LO;
            end
         end
         LO, HI: begin
            sram_addr = {word_q, (state_q == HI)};
            sram_we_n = ~op_wr_q;
            drive_dq  = op_wr_q;
            cnt_d     = cnt_q + 2'd1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = (state_q == LO) ? HI : DONE;
               if (!op_wr_q) begin
                  if (state_q == LO) rdata_d[15:0]  = sram_dq;
                  else               rdata_d[31:16] = sram_dq;
               end
            end
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: behavioural async SRAM, driver task per access,
// and a monitor that checks read_data against an expected queue on every completion.
module tb_sram_controller;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_we_n;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_ub_n;
   logic        sram_lb_n;
   logic [1:0]  dbg_state;

   logic [15:0] mem [0:262143];
   logic [31:0] exp_q[$];
   int          cmp_cnt;
   int          err_cnt;

   sram_controller #(.ACCESS_CYCLES(3), .BASE_ADDR(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .sram_dq    (sram_dq),
      .sram_addr  (sram_addr),
      .sram_we_n  (sram_we_n),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_ub_n  (sram_ub_n),
      .sram_lb_n  (sram_lb_n),
      .dbg_state_o(dbg_state)
   );

   // ---- clock ----
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---- SRAM model: output enable is tied on, so it drives whenever not writing ----
   assign sram_dq = sram_we_n ? mem[sram_addr] : 16'bz;

   always @(posedge clk) begin
      if (!sram_we_n) mem[sram_addr] <= sram_dq;
   end

   // ---- checking helpers ----
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---- driver: one access, starting at posedge+1, ending at posedge+1 of the cycle after DONE ----
   task automatic issue(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
      int lo_cnt;
      int we_cnt;
      exp_q.push_back(exp_rd);
      wr_en      = w;
      rd_en      = r;
      address    = a;
      write_data = d;
      lo_cnt     = 0;
      we_cnt     = 0;
      @(negedge clk);
      while (!ready && lo_cnt < 50) begin
         lo_cnt++;
         if (!sram_we_n) we_cnt++;
         @(negedge clk);
      end
      check("ready low cycles", 32'(lo_cnt), 32'd7);
      check("we_n low cycles", 32'(we_cnt), w ? 32'd6 : 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   // ---- monitor: a rising ready marks a completed access ----
   initial begin
      logic        prev;
      logic [31:0] exp;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b1;
         end else begin
            if (ready && !prev) begin
               if (exp_q.size() == 0) begin
                  check("unexpected completion", 32'd1, 32'd0);
               end else begin
                  exp = exp_q.pop_front();
                  check("read_data at DONE", read_data, exp);
               end
            end
            prev = ready;
         end
      end
   end

   // ---- watchdog ----
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---- stimulus ----
   initial begin
      cmp_cnt    = 0;
      err_cnt    = 0;
      rst        = 1'b1;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      address    = '0;
      write_data = '0;
      for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
      mem[0] = 16'hA55A;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Idle for 10 cycles
      repeat (10) @(negedge clk);
      check("idle ready", 32'(ready), 32'd1);
      check("idle we_n", 32'(sram_we_n), 32'd1);
      check("idle dq only sram", 32'(sram_dq), 32'h0000A55A);
      check("idle sram_addr", 32'(sram_addr), 32'd0);
      check("reset read_data", read_data, 32'd0);
      @(posedge clk);
      #1;

      // Store, load back, then a store that must not disturb read_data
      issue(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000);
      go_idle();
      check("mem[2]", 32'(mem[2]), 32'h0000BEEF);
      check("mem[3]", 32'(mem[3]), 32'h0000DEAD);
      @(posedge clk);
      #1;
      issue(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF);
      go_idle();
      @(posedge clk);
      #1;
      issue(1'b1, 1'b0, 32'd1036, 32'h0BADF00D, 32'hDEADBEEF);
      go_idle();
      check("mem[6]", 32'(mem[6]), 32'h0000F00D);
      check("mem[7]", 32'(mem[7]), 32'h00000BAD);

      // Back-to-back store then load at 1024, no gap
      issue(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 32'hDEADBEEF);
      issue(1'b0, 1'b1, 32'd1024, 32'h0, 32'hCAFEF00D);
      go_idle();

      // Both enables high: store wins
      @(posedge clk);
      #1;
      issue(1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hCAFEF00D);
      go_idle();
      check("mem[4]", 32'(mem[4]), 32'h00005678);
      check("mem[5]", 32'(mem[5]), 32'h00001234);

      // Reset while in LO of a write
      @(posedge clk);
      #1;
      wr_en      = 1'b1;
      address    = 32'd1040;
      write_data = 32'h11112222;
      @(posedge clk);
      #1;
      check("we_n low in LO", 32'(sram_we_n), 32'd0);
      rst = 1'b1;
      #1;
      check("rst we_n", 32'(sram_we_n), 32'd1);
      check("rst dq only sram", 32'(sram_dq), 32'h0000F00D);
      check("rst read_data", read_data, 32'd0);
      check("rst sram_addr", 32'(sram_addr), 32'd0);
      go_idle();
      #1;
      check("rst ready", 32'(ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post-rst ready", 32'(ready), 32'd1);
      check("post-rst we_n", 32'(sram_we_n), 32'd1);
      @(posedge clk);
      #1;

      // Address wrap: 2^17 words past the base lands on word 0
      issue(1'b0, 1'b1, 32'h00080400, 32'h0, 32'hCAFEF00D);
      go_idle();
      @(posedge clk);
      #1;
      // Below the base: word index wraps to 0x1FFFF
      issue(1'b1, 1'b0, 32'd1020, 32'h13572468, 32'hCAFEF00D);
      go_idle();
      check("mem[3fffe]", 32'(mem[18'h3FFFE]), 32'h00002468);
      check("mem[3ffff]", 32'(mem[18'h3FFFF]), 32'h00001357);

      repeat (5) @(negedge clk);
      check("expected queue drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
